// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl: EX-stage multiply/divide sequencing and HI/LO registers.
// Define MD_DIV0_GUARD_EN to resolve divide-by-zero without the divider.
module md_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        stall_in,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);
  localparam logic       MUL1     = (MUL_LAT == 1);

  state_t      state_q;
  state_t      done_nxt;
  logic [2:0]  cnt_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        sgn_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic op_mult, op_multu, op_div, op_divu;
  logic op_mthi, op_mtlo, op_mul, op_dv;
  logic idle, issue, mul_fire, div_fire, div0;

  assign op_mult  = (md_op == 3'b001);
  assign op_multu = (md_op == 3'b010);
  assign op_div   = (md_op == 3'b011);
  assign op_divu  = (md_op == 3'b100);
  assign op_mthi  = (md_op == 3'b101);
  assign op_mtlo  = (md_op == 3'b110);
  assign op_mul   = op_mult | op_multu;
  assign op_dv    = op_div | op_divu;

`ifdef MD_DIV0_GUARD_EN
  assign div0 = (src_b == 32'd0);
`else
  assign div0 = 1'b0;
`endif

  assign idle     = (state_q == S_IDLE);
  assign issue    = idle & md_valid & ~flush;
  assign mul_fire = issue & op_mul;
  assign div_fire = issue & op_dv & ~div0;
  assign done_nxt = stall_in ? S_DONE : S_IDLE;

  assign busy = ~idle;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Stall, handshake and operand steering for the current state.
  always_comb begin
    stallreq    = 1'b0;
    div_start   = 1'b0;
    div_annul   = 1'b0;
    mul_signed  = 1'b0;
    div_signed  = 1'b0;
    mul_ina     = 32'd0;
    mul_inb     = 32'd0;
    div_opdata1 = 32'd0;
    div_opdata2 = 32'd0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          stallreq    = (mul_fire & ~MUL1) | div_fire;
          div_start   = div_fire;
          div_annul   = flush & md_valid & op_dv;
          mul_signed  = issue & op_mult;
          div_signed  = issue & op_div;
          mul_ina     = src_a;
          mul_inb     = src_b;
          div_opdata1 = src_a;
          div_opdata2 = src_b;
        end
        S_MUL: begin
          stallreq    = ~flush & (cnt_q != 3'd0);
          mul_signed  = sgn_q;
          mul_ina     = opa_q;
          mul_inb     = opb_q;
          div_opdata1 = opa_q;
          div_opdata2 = opb_q;
        end
        S_DIV: begin
          stallreq    = ~flush & ~div_ready;
          div_start   = ~flush & ~div_ready;
          div_annul   = flush;
          div_signed  = sgn_q;
          mul_ina     = opa_q;
          mul_inb     = opb_q;
          div_opdata1 = opa_q;
          div_opdata2 = opb_q;
        end
        default: begin
          mul_ina     = opa_q;
          mul_inb     = opb_q;
          div_opdata1 = opa_q;
          div_opdata2 = opb_q;
        end
      endcase
    end
  end

  // Sequencer: issue, wait for the unit, commit to HI/LO, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (issue) begin
        opa_q <= src_a;
        opb_q <= src_b;
        sgn_q <= op_mult | op_div;
      end
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            if (op_mthi) hi_q <= src_a;
            if (op_mtlo) lo_q <= src_a;
            if (op_mul) begin
              if (MUL1) begin
                {hi_q, lo_q} <= mul_result;
                state_q      <= done_nxt;
              end else begin
                cnt_q   <= CNT_INIT;
                state_q <= S_MUL;
              end
            end
            if (op_dv) begin
              if (div0) begin
                hi_q    <= src_a;
                lo_q    <= 32'hFFFF_FFFF;
                state_q <= done_nxt;
              end else begin
                state_q <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            {hi_q, lo_q} <= mul_result;
            state_q      <= done_nxt;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (div_ready) begin
            hi_q    <= div_result[63:32];
            lo_q    <= div_result[31:0];
            state_q <= done_nxt;
          end
        end
        S_DONE: begin
          if (flush || !stall_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// tb_md_hilo_ctrl: directed and random stimulus for md_hilo_ctrl
// against a transaction-level model of mul/div/HI/LO behaviour.
module tb_md_hilo_ctrl;

  localparam int LAT = 2;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall_in = 1'b0;
  logic        stallreq, busy, mul_signed, div_start, div_signed, div_annul;
  logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2, hi_o, lo_o;
  logic [63:0] mul_result;
  logic [63:0] div_result = 64'd0;
  logic        div_ready = 1'b0;

  always #5 clk = ~clk;

  md_hilo_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall_in(stall_in),
    .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed),
    .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_annul(div_annul), .div_result(div_result),
    .div_ready(div_ready), .hi_o(hi_o), .lo_o(lo_o)
  );

  int vectors = 0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint na, nb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Multiplier environment: product appears LAT cycles after operands.
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mul_ref(mul_ina, mul_inb, mul_signed);
  end
  assign mul_result = mpipe[LAT-1];

  // Divider environment: ready pulses L cycles after the start cycle.
  int          force_lat = 0;
  logic        dbusy = 1'b0;
  int          dcnt = 0;
  logic [31:0] dA = 32'd0;
  logic [31:0] dB = 32'd0;
  logic        dS = 1'b0;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (rst || div_annul) begin
      dbusy <= 1'b0;
    end else if (dbusy) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        dbusy      <= 1'b0;
        div_ready  <= 1'b1;
        div_result <= div_ref(dA, dB, dS);
      end
    end else if (div_start) begin
      dbusy <= 1'b1;
      dA    <= div_opdata1;
      dB    <= div_opdata2;
      dS    <= div_signed;
      dcnt  <= (force_lat > 0 ? force_lat : int'($urandom_range(6, 2))) - 1;
    end
  end

  // Transaction model: kind 0 idle, 1 multiply, 2 divide, 3 committed-held.
  int          kind = 0;
  int          cyc = 0;
  int          t_iss = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] ta = 32'd0;
  logic [31:0] tb = 32'd0;
  logic        tsg = 1'b0;
  logic [63:0] tres = 64'd0;
  logic        e_stall = 1'b0;
  logic        e_start, e_annul, is_mul, is_div, act_m, act_d;

  task automatic retire();
    m_hi = tres[63:32];
    m_lo = tres[31:0];
    kind = stall_in ? 3 : 0;
  endtask

  always @(negedge clk) begin
    vectors++;
    cyc++;
    if (rst) begin
      chk1("rst_stallreq", stallreq, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_div_start", div_start, 1'b0);
      chk1("rst_div_annul", div_annul, 1'b0);
      chk1("rst_mul_signed", mul_signed, 1'b0);
      chk1("rst_div_signed", div_signed, 1'b0);
      chk32("rst_mul_ina", mul_ina, 32'd0);
      chk32("rst_mul_inb", mul_inb, 32'd0);
      chk32("rst_div_op1", div_opdata1, 32'd0);
      chk32("rst_div_op2", div_opdata2, 32'd0);
      chk32("rst_hi", hi_o, 32'd0);
      chk32("rst_lo", lo_o, 32'd0);
      kind = 0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      e_stall = 1'b0;
    end else begin
      chk32("hi", hi_o, m_hi);
      chk32("lo", lo_o, m_lo);
      chk1("busy", busy, kind != 0);
      e_stall = 1'b0;
      e_start = 1'b0;
      e_annul = 1'b0;
      act_m = 1'b0;
      act_d = 1'b0;
      is_mul = md_valid && (md_op == OP_MULT || md_op == OP_MULTU);
      is_div = md_valid && (md_op == OP_DIV || md_op == OP_DIVU);
      if (flush) begin
        e_annul = (kind == 2) || (kind == 0 && is_div);
        kind = 0;
      end else begin
        case (kind)
          0: begin
            if (md_valid && md_op == OP_MTHI) m_hi = src_a;
            if (md_valid && md_op == OP_MTLO) m_lo = src_a;
            if (is_mul || is_div) begin
              ta = src_a;
              tb = src_b;
              tsg = (md_op == OP_MULT) || (md_op == OP_DIV);
              t_iss = cyc;
            end
            if (is_mul) begin
              act_m = 1'b1;
              tres = mul_ref(ta, tb, tsg);
              if (LAT == 1) retire();
              else begin
                e_stall = 1'b1;
                kind = 1;
              end
            end
            if (is_div) begin
              act_d = 1'b1;
              tres = div_ref(ta, tb, tsg);
              if (GUARD && tb == 32'd0) retire();
              else begin
                e_stall = 1'b1;
                e_start = 1'b1;
                kind = 2;
              end
            end
          end
          1: begin
            act_m = 1'b1;
            if (cyc - t_iss < LAT) e_stall = 1'b1;
            else retire();
          end
          2: begin
            act_d = 1'b1;
            if (!div_ready) begin
              e_stall = 1'b1;
              e_start = 1'b1;
            end else retire();
          end
          default: if (!stall_in) kind = 0;
        endcase
      end
      chk1("stallreq", stallreq, e_stall);
      chk1("div_start", div_start, e_start);
      chk1("div_annul", div_annul, e_annul);
      if (act_m) begin
        chk32("mul_ina", mul_ina, ta);
        chk32("mul_inb", mul_inb, tb);
        chk1("mul_signed", mul_signed, tsg);
      end
      if (act_d) begin
        chk32("div_op1", div_opdata1, ta);
        chk32("div_op2", div_opdata2, tb);
        chk1("div_signed", div_signed, tsg);
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic st);
    @(posedge clk);
    #1;
    md_valid = v;
    md_op = op;
    src_a = a;
    src_b = b;
    flush = fl;
    stall_in = st;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(7, 0))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  int          n, ns;
  logic        cv, adv, fl, st;
  logic [2:0]  cop;
  logic [31:0] ca, cb;

  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
      md_valid = 1'b1;
      md_op = 3'($urandom_range(7, 0));
      src_a = $urandom;
      src_b = $urandom;
      flush = 1'($urandom_range(1, 0));
      stall_in = 1'($urandom_range(1, 0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    md_valid = 1'b0;
    md_op = OP_NONE;
    flush = 1'b0;
    stall_in = 1'b0;

    // MULT -3 * 5
    n = 0;
    repeat (3) begin
      step(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);
      n += int'(stallreq);
    end
    step(0, OP_NONE, 0, 0, 0, 0);
    chk32("mult_stall_cycles", 32'(n), 32'd2);
    chk32("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk32("mult_lo", lo_o, 32'hFFFF_FFF1);

    // DIVU 100 / 7 with a 33-cycle divider
    force_lat = 33;
    n = 0;
    ns = 0;
    step(1, OP_DIVU, 32'd100, 32'd7, 0, 0);
    for (int i = 0; i < 40; i++) begin
      n += int'(stallreq);
      ns += int'(div_start);
      if (!stallreq) break;
      step(1, OP_DIVU, 32'd100, 32'd7, 0, 0);
    end
    force_lat = 0;
    step(0, OP_NONE, 0, 0, 0, 0);
    chk32("divu_stall_cycles", 32'(n), 32'd33);
    chk32("divu_start_cycles", 32'(ns), 32'd33);
    chk32("divu_lo", lo_o, 32'd14);
    chk32("divu_hi", hi_o, 32'd2);

    // DIV -7 / 2
    step(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    for (int i = 0; i < 20 && stallreq; i++)
      step(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    step(0, OP_NONE, 0, 0, 0, 0);
    chk32("div_lo", lo_o, 32'hFFFF_FFFD);
    chk32("div_hi", hi_o, 32'hFFFF_FFFF);

    // MTHI then read
    step(1, OP_MTHI, 32'h1234_5678, 0, 0, 0);
    step(0, OP_NONE, 0, 0, 0, 0);
    chk32("mthi_hi", hi_o, 32'h1234_5678);

    // Flush on the 5th DIV_WAIT cycle
    step(1, OP_MTHI, 32'hA5A5_A5A5, 0, 0, 0);
    step(1, OP_MTLO, 32'hA5A5_A5A5, 0, 0, 0);
    force_lat = 20;
    step(1, OP_DIV, 32'd50, 32'd3, 0, 0);
    repeat (4) step(1, OP_DIV, 32'd50, 32'd3, 0, 0);
    step(1, OP_DIV, 32'd50, 32'd3, 1, 0);
    chk1("flush_annul", div_annul, 1'b1);
    chk1("flush_stallreq", stallreq, 1'b0);
    force_lat = 0;
    step(0, OP_NONE, 0, 0, 0, 0);
    chk1("flush_annul_drop", div_annul, 1'b0);
    chk1("flush_idle", busy, 1'b0);
    chk32("flush_hi", hi_o, 32'hA5A5_A5A5);
    chk32("flush_lo", lo_o, 32'hA5A5_A5A5);

    // MULT 7 * 6 completing under stall_in, instruction held
    step(1, OP_MULT, 32'd7, 32'd6, 0, 0);
    step(1, OP_MULT, 32'd7, 32'd6, 0, 0);
    step(1, OP_MULT, 32'd7, 32'd6, 0, 1);
    repeat (2) begin
      step(1, OP_MULT, 32'd7, 32'd6, 0, 1);
      chk1("done_stallreq", stallreq, 1'b0);
      chk1("done_busy", busy, 1'b1);
    end
    step(1, OP_MULT, 32'd7, 32'd6, 0, 0);
    chk1("done_exit_stallreq", stallreq, 1'b0);
    step(0, OP_NONE, 0, 0, 0, 0);
    chk1("done_back_idle", busy, 1'b0);
    chk32("done_hi", hi_o, 32'd0);
    chk32("done_lo", lo_o, 32'd42);

    // DIV 9 / 0
    step(1, OP_DIV, 32'd9, 32'd0, 0, 0);
`ifdef MD_DIV0_GUARD_EN
    chk1("div0_no_start", div_start, 1'b0);
    chk1("div0_no_stall", stallreq, 1'b0);
`endif
    for (int i = 0; i < 20 && stallreq; i++)
      step(1, OP_DIV, 32'd9, 32'd0, 0, 0);
    step(0, OP_NONE, 0, 0, 0, 0);
    chk32("div0_hi", hi_o, 32'd9);
    chk32("div0_lo", lo_o, 32'hFFFF_FFFF);

    // Random traffic; the instruction is held while the pipe is stalled
    adv = 1'b1;
    cv = 1'b0;
    cop = OP_NONE;
    ca = 32'd0;
    cb = 32'd0;
    for (int i = 0; i < 4000; i++) begin
      if (adv) begin
        cv = ($urandom_range(3, 0) != 0);
        cop = 3'($urandom_range(7, 0));
        ca = rnd32();
        cb = rnd32();
      end
      fl = ($urandom_range(15, 0) == 0);
      st = ($urandom_range(3, 0) == 0);
      step(cv, cop, ca, cb, fl, st);
      adv = fl || !(e_stall || st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, n_fail);
    $finish;
  end

endmodule
